pipelined_nibble_subtractor16: RTL and testbench
================================================

Name: pipelined_nibble_subtractor16

Overview:
- Four-stage pipelined 16-bit subtractor computing D = A - B - bin, one 4-bit nibble per stage, low nibble first. Borrow ripples between stages through registers.
- Subtraction counterpart of the team's nibble carry-lookahead adder. Used in the ALU/compare datapath where a registered, backpressure-aware result is needed.
- Valid/ready handshake on both sides. Sustains one operation per cycle.

Parameters:
- WIDTH, 16, operand/result width; must equal NIB*STAGES.
- NIB, 4, nibble width handled per stage.
- STAGES, 4, pipeline depth; WIDTH/NIB.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands this cycle
- a  input  16  minuend
- b  input  16  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- d  output  16  difference A - B - bin, mod 2^16
- bout  output  1  unsigned borrow-out; 1 iff A < B + bin
- ovf  output  1  two's-complement overflow: a[15] != b[15] and d[15] != a[15]
- zero  output  1  d == 16'h0000

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low. No synchronous clear.
- Reset state:
  - all stage valid bits 0 and all data registers 0;
  - out_valid=0, d=0, bout=0, ovf=0, zero=0;
  - in_ready=1 while rst_n is low and after release.
- Stage k (k=1..4) register contents:
  - valid bit v_k;
  - result nibbles 0..k-1;
  - remaining operand nibbles k..3 of a and b;
  - a[15], b[15], for ovf;
  - the borrow out of nibble k-1.
- Nibble computation:
  - Stage 1 captures nibble 0, computed combinationally from a[3:0], b[3:0], bin, on the accepting edge.
  - Stage k+1 computes nibble k from stage k's registered operands and borrow.
  - Each nibble uses borrow generate g_i = ~a_i & b_i and borrow propagate p_i = ~(a_i ^ b_i).
  - Lookahead within the nibble (no ripple inside).
- Stage 4 is the output register:
  - d = stage-4 result; bout = stage-4 borrow; out_valid = v_4;
  - ovf and zero are registered into stage 4, not decoded combinationally at the output.
- Advance rules:
  - adv_4 = v_4 & out_ready;
  - adv_k = v_k & (~v_{k+1} | adv_{k+1}) for k=1..3;
  - in_ready = ~v_1 | adv_1. This is a combinational ready chain from out_ready; no bubble is inserted.
  - Stage k+1 loads when adv_k. Otherwise v_{k+1} clears when adv_{k+1}, and holds otherwise.
  - Stage 1 loads when in_valid & in_ready.
- Latency and throughput:
  - The accepting edge counts as edge 1. out_valid rises after edge 4 when there is no stall.
  - Back-to-back accepts yield back-to-back results.
- Backpressure:
  - While out_valid=1 and out_ready=0, d/bout/ovf/zero are held bit-stable.
  - The pipe fills; after 4 accepted and unconsumed operations, in_ready=0.
  - Simultaneous accept and drain when full is legal and loses nothing.
- No data-dependent wrap behaviour: arithmetic is modulo 2^16; bout carries the 17th bit.
- Ordering: results leave in acceptance order. No operation is dropped or duplicated.
- Reset mid-operation: all in-flight operations are discarded immediately (asynchronous); out_valid drops in the same instant rst_n falls.
- Values on a/b/bin while in_valid=0 have no effect.

Decomposition:
- Shared package/include: WIDTH, NIB, STAGES constants, and a stage-record typedef (valid, result, pending operands, borrow, sign bits).
- One sub-module: nibble_borrow_lookahead4, combinational.
  - Inputs: a[3:0], b[3:0], bin.
  - Outputs: d[3:0], bout, group borrow-generate GG, group borrow-propagate PG.
  - GG/PG are exported for a future single-cycle inter-nibble borrow-lookahead variant.
- Instantiated four times, one per stage.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release, with in_valid=0 -> out_valid=0, d=0, flags 0, in_ready=1.
- Single op: a=16'h1234, b=16'h0235, bin=0, out_ready=1 -> after 4 edges out_valid=1 for one cycle, d=16'h0FFF, bout=0, ovf=0, zero=0. Exercises nibble-to-nibble borrow ripple.
- Boundaries, streamed back-to-back with out_ready=1 -> results in order, one per cycle:
  - (0x0000, 0x0001, 0) -> d=0xFFFF, bout=1, ovf=0;
  - (0x8000, 0x0001, 0) -> d=0x7FFF, bout=0, ovf=1;
  - (0x7FFF, 0xFFFF, 0) -> d=0x8000, bout=1, ovf=1;
  - (0x5A5A, 0x5A59, 1) -> d=0x0000, zero=1, bout=0.
- Backpressure: out_ready=0 while issuing 6 ops with in_valid=1 continuously -> exactly 4 accepted, in_ready=0 afterward, d stable. Raise out_ready -> the 6 results emerge in order with no gaps once flowing.
- Full-throughput drain: pipe full, out_ready=1 and in_valid=1 on the same cycle -> in_ready=1, one accept and one retire per cycle, occupancy stays 4.
- Async reset mid-flight: 3 ops in flight, pulse rst_n low between clock edges -> out_valid=0 immediately. After release, no stale result ever appears.

Source files
------------

// File: rtl/pipelined_nibble_subtractor16_pkg.sv
// Shared constants and the per-stage pipeline record for the nibble-serial subtractor.
package pipelined_nibble_subtractor16_pkg;

  localparam int WIDTH  = 16;
  localparam int NIB    = 4;
  localparam int STAGES = WIDTH / NIB;

  // One pipeline stage: finished result nibbles, operands still to be consumed,
  // the borrow into the next nibble, and the sign bits needed for overflow.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             brw;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;
    logic             zero;
  } stage_t;

endpackage

// File: rtl/pipelined_nibble_subtractor16_if.sv
// Operand/result handshake bundle between a producer/consumer (master) and the subtractor (slave).
interface pipelined_nibble_subtractor16_if;
  import pipelined_nibble_subtractor16_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf, zero
  );

endinterface

// File: rtl/nibble_borrow_lookahead4.sv
// Combinational 4-bit subtract slice with full borrow lookahead; exports group generate/propagate.
module nibble_borrow_lookahead4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_bin,
  output logic [3:0] o_d,
  output logic       o_bout,
  output logic       o_gg,
  output logic       o_pg
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
  assign w_g = ~i_a & i_b;
  assign w_p = ~(i_a ^ i_b);

  assign w_c[0] = i_bin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_bin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_bin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_bin);

  assign o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_pg   = &w_p;
  assign o_bout = o_gg | (o_pg & i_bin);
  assign o_d    = i_a ^ i_b ^ w_c;

endmodule

// File: rtl/pipelined_nibble_subtractor16.sv
// Four-stage 16-bit subtractor D = A - B - bin, one nibble per stage, with a
// combinational ready chain so a full pipe can accept and retire in the same cycle.
module pipelined_nibble_subtractor16
  import pipelined_nibble_subtractor16_pkg::*;
(
  input logic                              clk,
  input logic                              rst_n,
  pipelined_nibble_subtractor16_if.slave   io
);

  stage_t            r_stg [STAGES];
  stage_t            w_nxt [STAGES];
  logic [NIB-1:0]    w_na  [STAGES];
  logic [NIB-1:0]    w_nb  [STAGES];
  logic [NIB-1:0]    w_dn  [STAGES];
  logic [STAGES-1:0] w_nbi;
  logic [STAGES-1:0] w_bo;
  logic [STAGES-1:0] w_gg;
  logic [STAGES-1:0] w_pg;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic              w_acc;
  logic              w_unused_gp;

  // Group generate/propagate are kept for a future single-cycle lookahead variant.
  assign w_unused_gp = ^{w_gg, w_pg};

  // Operand selection: stage 1 works on the live inputs, later stages on registered operands.
  always_comb begin
    w_na[0]  = io.a[NIB-1:0];
    w_nb[0]  = io.b[NIB-1:0];
    w_nbi[0] = io.bin;
    for (int k = 1; k < STAGES; k++) begin
      w_na[k]  = r_stg[k-1].opa[k*NIB +: NIB];
      w_nb[k]  = r_stg[k-1].opb[k*NIB +: NIB];
      w_nbi[k] = r_stg[k-1].brw;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_nib
    nibble_borrow_lookahead4 u_nib (
      .i_a    (w_na[k]),
      .i_b    (w_nb[k]),
      .i_bin  (w_nbi[k]),
      .o_d    (w_dn[k]),
      .o_bout (w_bo[k]),
      .o_gg   (w_gg[k]),
      .o_pg   (w_pg[k])
    );
  end

  always_comb begin
    w_nxt[0]               = '0;
    w_nxt[0].vld           = 1'b1;
    w_nxt[0].res[NIB-1:0]  = w_dn[0];
    w_nxt[0].opa           = io.a;
    w_nxt[0].opb           = io.b;
    w_nxt[0].brw           = w_bo[0];
    w_nxt[0].a_msb         = io.a[WIDTH-1];
    w_nxt[0].b_msb         = io.b[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      w_nxt[k]                   = '0;
      w_nxt[k].vld               = 1'b1;
      w_nxt[k].res               = r_stg[k-1].res;
      w_nxt[k].res[k*NIB +: NIB] = w_dn[k];
      w_nxt[k].opa               = r_stg[k-1].opa;
      w_nxt[k].opb               = r_stg[k-1].opb;
      w_nxt[k].brw               = w_bo[k];
      w_nxt[k].a_msb             = r_stg[k-1].a_msb;
      w_nxt[k].b_msb             = r_stg[k-1].b_msb;
    end
    // Flags are decoded once the last nibble is known and registered with it.
    w_nxt[STAGES-1].ovf  = (w_nxt[STAGES-1].a_msb != w_nxt[STAGES-1].b_msb)
                         & (w_nxt[STAGES-1].res[WIDTH-1] != w_nxt[STAGES-1].a_msb);
    w_nxt[STAGES-1].zero = ~|w_nxt[STAGES-1].res;
  end

  // Advance chain runs from the output back to the input in one cycle.
  always_comb begin
    w_adv             = '0;
    w_adv[STAGES-1]   = r_stg[STAGES-1].vld & io.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_adv[k] = r_stg[k].vld & (~r_stg[k+1].vld | w_adv[k+1]);
    end
  end

  assign io.in_ready = ~r_stg[0].vld | w_adv[0];
  assign w_acc       = io.in_valid & io.in_ready;
  assign w_load      = {w_adv[STAGES-2:0], w_acc};

  // Stage boundaries 1..STAGES: load from upstream, else empty when drained, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_stg[k] <= w_nxt[k];
        end else if (w_adv[k]) begin
          r_stg[k].vld <= 1'b0;
        end
      end
    end
  end

  assign io.out_valid = r_stg[STAGES-1].vld;
  assign io.d         = r_stg[STAGES-1].res;
  assign io.bout      = r_stg[STAGES-1].brw;
  assign io.ovf       = r_stg[STAGES-1].ovf;
  assign io.zero      = r_stg[STAGES-1].zero;

endmodule

// File: tb/tb_pipelined_nibble_subtractor16.sv
// Scoreboard bench for the pipelined nibble subtractor: directed corners, backpressure, reset, random traffic.
module tb_pipelined_nibble_subtractor16;

  typedef struct packed {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pipelined_nibble_subtractor16_if ifc ();

  pipelined_nibble_subtractor16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (ifc)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_pass     = 0;
  int   n_total    = 0;
  int   n_acc      = 0;
  int   n_out_seen = 0;
  logic last_ov    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bi);
    exp_t m;
    int ua, ub, ubi, sa, sb, sd, diff;
    ua   = {16'b0, a};
    ub   = {16'b0, b};
    ubi  = {31'b0, bi};
    sa   = {{16{a[15]}}, a};
    sb   = {{16{b[15]}}, b};
    diff = ua - ub - ubi;
    sd   = sa - sb - ubi;
    m.d    = diff[15:0];
    m.bout = (ua < ub + ubi);
    m.ovf  = (sd > 32767) || (sd < -32768);
    m.zero = (m.d == 16'h0000);
    return m;
  endfunction

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic bi,
                      input logic ordy, input exp_t e, output logic acc);
    ifc.in_valid  = v;
    ifc.a         = a;
    ifc.b         = b;
    ifc.bin       = bi;
    ifc.out_ready = ordy;
    @(negedge clk);
    acc     = v & ifc.in_ready;
    last_ov = ifc.out_valid;
    @(posedge clk);
    #1;
    if (acc) begin
      sb_q.push_back(e);
      n_acc++;
    end
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), ordy, '0, acc);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) idle(1'b1);
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: pops on every retiring result and checks hold stability under backpressure.
  initial begin : monitor
    exp_t got;
    exp_t held;
    logic held_vld;
    held_vld = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_vld = 1'b0;
      end else begin
        got = {ifc.d, ifc.bout, ifc.ovf, ifc.zero};
        if (held_vld && ifc.out_valid) chk("hold_stable", 32'(got), 32'(held));
        held_vld = ifc.out_valid && !ifc.out_ready;
        held     = got;
        if (ifc.out_valid && ifc.out_ready) begin
          n_out_seen++;
          if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_result: got d=%h with empty scoreboard, required no result", ifc.d);
          end else begin
            chk("result", 32'(got), 32'(sb_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

  initial begin : stim
    logic        acc;
    logic [15:0] ba [4];
    logic [15:0] bb [4];
    logic        bbi[4];
    exp_t        be [4];
    logic [15:0] pa [6];
    logic [15:0] pb [6];
    logic        pbi[6];
    int          n0;
    int          idx;
    int          seen0;

    ifc.in_valid  = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.bin       = 1'b0;
    ifc.out_ready = 1'b1;

    // Reset / idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready_low", 32'(ifc.in_ready), 32'd1);
    chk("rst_out_valid_low", 32'(ifc.out_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("idle_d", 32'(ifc.d), 32'd0);
    chk("idle_flags", 32'({ifc.bout, ifc.ovf, ifc.zero}), 32'd0);
    chk("idle_in_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single op with nibble-to-nibble borrow ripple
    step(1'b1, 16'h1234, 16'h0235, 1'b0, 1'b1, {16'h0FFF, 1'b0, 1'b0, 1'b0}, acc);
    chk("single_accept", 32'(acc), 32'd1);
    ifc.in_valid = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      chk($sformatf("single_latency_edge%0d", e), 32'(ifc.out_valid), 32'(e == 4));
      @(posedge clk);
      #1;
    end

    // Boundary operands streamed back-to-back
    ba[0] = 16'h0000; bb[0] = 16'h0001; bbi[0] = 1'b0; be[0] = {16'hFFFF, 1'b1, 1'b0, 1'b0};
    ba[1] = 16'h8000; bb[1] = 16'h0001; bbi[1] = 1'b0; be[1] = {16'h7FFF, 1'b0, 1'b1, 1'b0};
    ba[2] = 16'h7FFF; bb[2] = 16'hFFFF; bbi[2] = 1'b0; be[2] = {16'h8000, 1'b1, 1'b1, 1'b0};
    ba[3] = 16'h5A5A; bb[3] = 16'h5A59; bbi[3] = 1'b1; be[3] = {16'h0000, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ba[i], bb[i], bbi[i], 1'b1, be[i], acc);
      chk($sformatf("bound_accept%0d", i), 32'(acc), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk($sformatf("bound_stream_valid%0d", i), 32'(last_ov), 32'd1);
    end
    drain("bound_drained");

    // Backpressure: six ops offered continuously into a stalled pipe
    for (int i = 0; i < 6; i++) begin
      pa[i] = 16'($urandom); pb[i] = 16'($urandom); pbi[i] = 1'($urandom);
    end
    n0  = n_acc;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, pa[idx], pb[idx], pbi[idx], 1'b0, model(pa[idx], pb[idx], pbi[idx]), acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(n_acc - n0), 32'd4);
    @(negedge clk);
    chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
    chk("bp_out_valid", 32'(ifc.out_valid), 32'd1);
    @(posedge clk);
    #1;
    for (int c = 0; c < 6; c++) begin
      step(idx < 6, pa[idx % 6], pb[idx % 6], pbi[idx % 6], 1'b1,
           model(pa[idx % 6], pb[idx % 6], pbi[idx % 6]), acc);
      if (acc) idx++;
      chk($sformatf("bp_no_gap%0d", c), 32'(last_ov), 32'd1);
    end
    chk("bp_all_accepted", 32'(idx), 32'd6);
    drain("bp_drained");

    // Full-throughput: fill, then accept and retire every cycle
    for (int i = 0; i < 4; i++) begin
      pa[0] = 16'($urandom); pb[0] = 16'($urandom); pbi[0] = 1'($urandom);
      step(1'b1, pa[0], pb[0], pbi[0], 1'b0, model(pa[0], pb[0], pbi[0]), acc);
    end
    for (int i = 0; i < 8; i++) begin
      pa[0] = 16'($urandom); pb[0] = 16'($urandom); pbi[0] = 1'($urandom);
      step(1'b1, pa[0], pb[0], pbi[0], 1'b1, model(pa[0], pb[0], pbi[0]), acc);
      chk($sformatf("ft_accept%0d", i), 32'(acc), 32'd1);
      chk($sformatf("ft_valid%0d", i), 32'(last_ov), 32'd1);
    end
    drain("ft_drained");

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      pa[0]  = 16'($urandom);
      pb[0]  = 16'($urandom);
      pbi[0] = 1'($urandom);
      if ($urandom_range(0, 7) == 0) pa[0] = pb[0];
      if ($urandom_range(0, 7) == 0) pb[0] = 16'h8000;
      step($urandom_range(0, 9) < 7, pa[0], pb[0], pbi[0], $urandom_range(0, 3) != 0,
           model(pa[0], pb[0], pbi[0]), acc);
    end
    drain("rand_drained");

    // Asynchronous reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      pa[0] = 16'($urandom); pb[0] = 16'($urandom); pbi[0] = 1'($urandom);
      step(1'b1, pa[0], pb[0], pbi[0], 1'b1, model(pa[0], pb[0], pbi[0]), acc);
    end
    ifc.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("prereset_out_valid", 32'(ifc.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("async_reset_in_ready", 32'(ifc.in_ready), 32'd1);
    sb_q.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    seen0 = n_out_seen;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      chk($sformatf("post_reset_quiet%0d", i), 32'(last_ov), 32'd0);
    end
    chk("post_reset_no_stale", 32'(n_out_seen - seen0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
